ptp_tsu_sfd_queue: RTL and testbench
====================================

// Module: ptp_tsu_sfd_queue
// PURPOSE
//  Single-clock, parametrised successor to the GMII time-stamping unit; rtc and datapath share clk.
//  - Detects preamble and SFD on the byte stream, then captures the RTC time exactly at the SFD byte.
//  - Pairs each capture with the parser verdict for the same frame.
//  - Queues {sec, ns, info} entries in a DEPTH-entry first-word-fall-through (FWFT) FIFO for the host, with drop accounting.
// PARAMETERS
//  SEC_W    48  RTC seconds width
//  NS_W     32  RTC nanoseconds width
//  INFO_W   32  parser info width (msgId/ckSum/seqId)
//  DEPTH    16  queue entries, power of 2, >=2
//  PRE_MAX  7   max 0x55 preamble bytes accepted before SFD
// PORTS
//  clk           in   1              single clock (byte clock, rtc domain)
//  rst_n         in   1              async active-low reset
//  gmii_ctrl     in   1              byte valid (RX_DV)
//  gmii_data     in   8              byte
//  rtc_sec       in   SEC_W          RTC seconds
//  rtc_ns        in   NS_W           RTC ns, always <1e9
//  ts_corr_ns    in   16             signed ingress latency correction (used only with TS_CORR_EN)
//  ptp_valid     in   1              parser verdict strobe, 1 cycle, once per frame
//  ptp_found     in   1              verdict: frame is a PTP message of interest
//  ptp_infor     in   INFO_W         parser info, valid with ptp_valid
//  q_rd_en       in   1              pop head entry
//  q_rd_valid    out  1              queue non-empty (head valid)
//  q_rd_data     out  SEC_W+NS_W+INFO_W  {sec, ns, info} head entry
//  q_count       out  $clog2(DEPTH)+1    occupancy
//  q_drop_cnt    out  16             saturating count of pushes lost to full
//  sfd_err       out  1              1-cycle pulse: bad preamble/SFD
//  ts_stale      out  1              1-cycle pulse: pending stamp overwritten unused
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pend_vld=0, FIFO empty, counters 0.
//  FSM; gmii_ctrl=0 forces IDLE from any state.
//  - IDLE: ctrl&data==55 -> PRE with precnt=1; ctrl&other byte -> DROP with sfd_err.
//  - PRE: 55 & precnt<PRE_MAX -> PRE with precnt+1.
//  - PRE: D5 -> FRAME and capture rtc_sec/rtc_ns from the same cycle.
//  - PRE: any other byte, or 55 at precnt==PRE_MAX -> DROP with sfd_err.
//  - FRAME, DROP: hold until ctrl=0.
//  Pending stamp: pend_vld rises 1 cycle after the SFD cycle (2 with TS_CORR_EN).
//  - Capture while pend_vld=1 and no same-cycle ptp_valid: overwrite the stamp and pulse ts_stale.
//  Verdict on ptp_valid:
//  - pend_vld & ptp_found: push {pend_sec, pend_ns, ptp_infor}.
//  - In all cases ptp_valid clears pend_vld.
//  - ptp_valid with pend_vld=0: ignored.
//  - Same-cycle verdict and new capture: push uses the old stamp; the new stamp becomes pending; no ts_stale.
//  FIFO, FWFT:
//  - q_rd_data is the head whenever q_rd_valid=1. Push is visible at the head 1 cycle later.
//  - Pop occurs on q_rd_en&q_rd_valid. q_rd_en while empty is ignored; no underflow.
//  - Full & push & pop in the same cycle: both occur, occupancy unchanged.
//  - Full & push & no pop: entry dropped, q_drop_cnt+1, saturating at 16'hFFFF.
//  - Pointers wrap modulo DEPTH.
//  Reset mid-frame: FSM returns to IDLE and the pending stamp is lost; the rest of the frame is treated as DROP until ctrl=0.
// CONFIGURATION
//  TS_CORR_EN defined:
//  - Capture adds sign-extended ts_corr_ns to ns, with one extra pipeline cycle.
//  - Result >=1e9: ns-=1e9, sec+=1.
//  - Result <0: ns+=1e9, sec-=1.
//  - sec wraps modulo 2^SEC_W.
//  TS_CORR_EN undefined:
//  - Raw capture; ts_corr_ns unused.
//  - pend_vld at SFD+1.
// TESTING
//  1. 7x55, D5 at rtc={5,100}, later ptp_valid&found, info=0x1234ABCD -> one entry {5,100,0x1234ABCD}; q_count=1.
//  2. Preamble 55,55,AA -> sfd_err pulse at the AA byte; no capture; a subsequent verdict pushes nothing.
//  3. Two frames, no verdict in between -> ts_stale once; a later found verdict pushes the second stamp only.
//  4. DEPTH+3 found frames, no reads -> q_count=DEPTH, q_drop_cnt=3; draining returns the first DEPTH entries in order.
//  5. Full, push+pop same cycle -> q_count stays DEPTH, q_drop_cnt unchanged.
//  6. TS_CORR_EN, rtc={9,999_999_990}, corr=+20 -> {10,10}; rtc={9,5}, corr=-10 -> {8,999_999_995}.

Source files
------------

// File: rtl/ptp_tsu_sfd_queue.sv
// rtl/ptp_tsu_sfd_queue.sv - GMII SFD time-stamp capture paired with parser verdicts, queued in an FWFT FIFO.
// Optional: define TS_CORR_EN to apply the signed ingress latency correction to each capture.
module ptp_tsu_sfd_queue #(
  parameter int SEC_W   = 48,
  parameter int NS_W    = 32,
  parameter int INFO_W  = 32,
  parameter int DEPTH   = 16,
  parameter int PRE_MAX = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gmii_ctrl,
  input  logic [7:0]                    gmii_data,
  input  logic [SEC_W-1:0]              rtc_sec,
  input  logic [NS_W-1:0]               rtc_ns,
  input  logic [15:0]                   ts_corr_ns,
  input  logic                          ptp_valid,
  input  logic                          ptp_found,
  input  logic [INFO_W-1:0]             ptp_infor,
  input  logic                          q_rd_en,
  output logic                          q_rd_valid,
  output logic [SEC_W+NS_W+INFO_W-1:0]  q_rd_data,
  output logic [$clog2(DEPTH):0]        q_count,
  output logic [15:0]                   q_drop_cnt,
  output logic                          sfd_err,
  output logic                          ts_stale
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PRE_MAX + 1);
  localparam int EW = SEC_W + NS_W + INFO_W;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_DROP} state_t;

  state_t          state_q;
  logic [PW-1:0]   precnt_q;
  logic            armed_q;
  logic            sfd_err_q;
  logic            sfd_hit;

  // armed_q stays low after reset until the line goes idle, so a frame cut by reset is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      precnt_q  <= '0;
      armed_q   <= 1'b0;
      sfd_err_q <= 1'b0;
    end else begin
      sfd_err_q <= 1'b0;
      if (!gmii_ctrl) begin
        state_q <= S_IDLE;
        armed_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!armed_q) begin
              state_q <= S_DROP;
            end else if (gmii_data == 8'h55) begin
              state_q  <= S_PRE;
              precnt_q <= PW'(1);
            end else begin
              state_q   <= S_DROP;
              sfd_err_q <= 1'b1;
            end
          end
          S_PRE: begin
            if (gmii_data == 8'hD5) begin
              state_q <= S_FRAME;
            end else if (gmii_data == 8'h55 && precnt_q < PW'(PRE_MAX)) begin
              precnt_q <= precnt_q + PW'(1);
            end else begin
              state_q   <= S_DROP;
              sfd_err_q <= 1'b1;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign sfd_hit = gmii_ctrl && (state_q == S_PRE) && (gmii_data == 8'hD5);

  logic             cap_vld;
  logic [SEC_W-1:0] cap_sec;
  logic [NS_W-1:0]  cap_ns;

`ifdef TS_CORR_EN
  localparam logic signed [NS_W+1:0] ONE_SEC = (NS_W+2)'(1000000000);

  logic                    stg_vld_q;
  logic [SEC_W-1:0]        stg_sec_q;
  logic [NS_W-1:0]         stg_ns_q;
  logic [15:0]             stg_corr_q;
  logic signed [NS_W+1:0]  corr_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q  <= 1'b0;
      stg_sec_q  <= '0;
      stg_ns_q   <= '0;
      stg_corr_q <= '0;
    end else begin
      stg_vld_q <= sfd_hit;
      if (sfd_hit) begin
        stg_sec_q  <= rtc_sec;
        stg_ns_q   <= rtc_ns;
        stg_corr_q <= ts_corr_ns;
      end
    end
  end

  // rtc_ns < 1e9 and |corr| < 2^15, so one borrow/carry into seconds is enough
  always_comb begin
    corr_sum = $signed({2'b00, stg_ns_q}) + $signed({{(NS_W-14){stg_corr_q[15]}}, stg_corr_q});
    cap_vld  = stg_vld_q;
    cap_sec  = stg_sec_q;
    cap_ns   = NS_W'(corr_sum);
    if (corr_sum >= ONE_SEC) begin
      cap_ns  = NS_W'(corr_sum - ONE_SEC);
      cap_sec = stg_sec_q + SEC_W'(1);
    end else if (corr_sum[NS_W+1]) begin
      cap_ns  = NS_W'(corr_sum + ONE_SEC);
      cap_sec = stg_sec_q - SEC_W'(1);
    end
  end
`else
  logic unused_corr;
  assign unused_corr = ^ts_corr_ns;

  always_comb begin
    cap_vld = sfd_hit;
    cap_sec = rtc_sec;
    cap_ns  = rtc_ns;
  end
`endif

  logic             pend_vld_q, pend_vld_d;
  logic [SEC_W-1:0] pend_sec_q;
  logic [NS_W-1:0]  pend_ns_q;
  logic             ts_stale_q, ts_stale_d;
  logic             push;

  // a same-cycle verdict consumes the old stamp before the new one lands, so no stale pulse
  always_comb begin
    push       = ptp_valid && pend_vld_q && ptp_found;
    ts_stale_d = cap_vld && pend_vld_q && !ptp_valid;
    pend_vld_d = pend_vld_q;
    if (ptp_valid) pend_vld_d = 1'b0;
    if (cap_vld)   pend_vld_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_sec_q <= '0;
      pend_ns_q  <= '0;
      ts_stale_q <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      ts_stale_q <= ts_stale_d;
      if (cap_vld) begin
        pend_sec_q <= cap_sec;
        pend_ns_q  <= cap_ns;
      end
    end
  end

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [15:0]    drop_q;
  logic           pop, full, wr_en, drop;

  always_comb begin
    pop   = q_rd_en && (count_q != '0);
    full  = (count_q == CW'(DEPTH));
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pend_sec_q, pend_ns_q, ptp_infor};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign q_rd_valid = (count_q != '0);
  assign q_rd_data  = q_rd_valid ? mem_q[rd_ptr_q] : '0;
  assign q_count    = count_q;
  assign q_drop_cnt = drop_q;
  assign sfd_err    = sfd_err_q;
  assign ts_stale   = ts_stale_q;

endmodule

// File: tb/tb_ptp_tsu_sfd_queue.sv
// tb/tb_ptp_tsu_sfd_queue.sv - Directed bench with a frame-level reference model for ptp_tsu_sfd_queue.
module tb_ptp_tsu_sfd_queue;
  localparam int DEPTH   = 16;
  localparam int PRE_MAX = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         gmii_ctrl;
  logic [7:0]   gmii_data;
  logic [47:0]  rtc_sec;
  logic [31:0]  rtc_ns;
  logic [15:0]  ts_corr_ns;
  logic         ptp_valid, ptp_found;
  logic [31:0]  ptp_infor;
  logic         q_rd_en;
  logic         q_rd_valid;
  logic [111:0] q_rd_data;
  logic [4:0]   q_count;
  logic [15:0]  q_drop_cnt;
  logic         sfd_err, ts_stale;

  int total = 0;
  int bad   = 0;
  int stale_seen = 0;

  ptp_tsu_sfd_queue #(.SEC_W(48), .NS_W(32), .INFO_W(32), .DEPTH(DEPTH), .PRE_MAX(PRE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_ctrl(gmii_ctrl), .gmii_data(gmii_data),
    .rtc_sec(rtc_sec), .rtc_ns(rtc_ns), .ts_corr_ns(ts_corr_ns),
    .ptp_valid(ptp_valid), .ptp_found(ptp_found), .ptp_infor(ptp_infor),
    .q_rd_en(q_rd_en), .q_rd_valid(q_rd_valid), .q_rd_data(q_rd_data),
    .q_count(q_count), .q_drop_cnt(q_drop_cnt), .sfd_err(sfd_err), .ts_stale(ts_stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-prefix preamble rule, a pending stamp, and a plain queue of entries.
  logic [111:0] mq[$];
  int           m_drop = 0;
  bit           m_sfd_err = 0, m_stale = 0;
  bit           p_vld = 0;
  logic [47:0]  p_sec = '0;
  logic [31:0]  p_ns = '0;
  bit           f_vld = 0;
  logic [47:0]  f_sec = '0;
  logic [31:0]  f_ns = '0;
  bit           decided = 1;
  int           n55 = 0;

  always @(posedge clk) begin : model
    bit          cap_now, arrive, pop, do_push;
    logic [47:0] a_sec, c_sec;
    logic [31:0] a_ns;
    longint      s;
    if (!rst_n) begin
      mq.delete(); m_drop = 0; m_sfd_err = 0; m_stale = 0;
      p_vld = 0; f_vld = 0; decided = 1; n55 = 0;
    end else begin
      m_sfd_err = 0; m_stale = 0; cap_now = 0;
      if (!gmii_ctrl) begin
        decided = 0; n55 = 0;
      end else if (!decided) begin
        if (gmii_data == 8'h55 && n55 < PRE_MAX) n55++;
        else if (gmii_data == 8'hD5 && n55 >= 1) begin cap_now = 1; decided = 1; end
        else begin m_sfd_err = 1; decided = 1; end
      end
`ifdef TS_CORR_EN
      arrive = f_vld; a_sec = f_sec; a_ns = f_ns;
      s = longint'(rtc_ns) + longint'($signed(ts_corr_ns));
      c_sec = rtc_sec;
      if (s >= 1000000000) begin s = s - 1000000000; c_sec = c_sec + 48'd1; end
      else if (s < 0) begin s = s + 1000000000; c_sec = c_sec - 48'd1; end
      f_vld = cap_now; f_sec = c_sec; f_ns = 32'(s);
`else
      arrive = cap_now; a_sec = rtc_sec; a_ns = rtc_ns;
      c_sec = '0; s = 0;
`endif
      pop     = q_rd_en && mq.size() > 0;
      do_push = ptp_valid && p_vld && ptp_found;
      if (do_push) begin
        if (pop) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back({p_sec, p_ns, ptp_infor});
        else if (m_drop < 65535) m_drop++;
      end else if (pop) begin
        void'(mq.pop_front());
      end
      m_stale = arrive && p_vld && !ptp_valid;
      if (ptp_valid) p_vld = 0;
      if (arrive) begin p_vld = 1; p_sec = a_sec; p_ns = a_ns; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_valid", 128'(q_rd_valid), 128'(mq.size() != 0));
      chk("rd_data", 128'(q_rd_data), (mq.size() != 0) ? 128'(mq[0]) : 128'd0);
      chk("count", 128'(q_count), 128'(mq.size()));
      chk("drop_cnt", 128'(q_drop_cnt), 128'(m_drop));
      chk("sfd_err", 128'(sfd_err), 128'(m_sfd_err));
      chk("ts_stale", 128'(ts_stale), 128'(m_stale));
      if (ts_stale) stale_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int npre, input logic [7:0] sfd, input logic [47:0] sec,
                            input logic [31:0] ns, input bit v_at_sfd, input logic [31:0] info);
    gmii_ctrl = 1'b1;
    for (int i = 0; i < npre; i++) begin
      gmii_data = 8'h55; rtc_sec = sec; rtc_ns = ns + 32'(i) + 32'd1; tick();
    end
    gmii_data = sfd; rtc_sec = sec; rtc_ns = ns;
    if (v_at_sfd) begin ptp_valid = 1'b1; ptp_found = 1'b1; ptp_infor = info; end
    tick();
    ptp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gmii_data = 8'h10 + 8'(i); rtc_ns = ns + 32'(i) + 32'd50; tick();
    end
    gmii_ctrl = 1'b0; gmii_data = 8'h00; tick();
  endtask

  task automatic verdict(input bit found, input logic [31:0] info, input bit rd);
    ptp_valid = 1'b1; ptp_found = found; ptp_infor = info; q_rd_en = rd;
    tick();
    ptp_valid = 1'b0; ptp_found = 1'b0; q_rd_en = 1'b0;
  endtask

  task automatic pop1();
    q_rd_en = 1'b1; tick(); q_rd_en = 1'b0;
  endtask

  initial begin
    int s0;
    rst_n = 1'b0; gmii_ctrl = 1'b0; gmii_data = 8'h00; rtc_sec = '0; rtc_ns = '0;
    ts_corr_ns = '0; ptp_valid = 1'b0; ptp_found = 1'b0; ptp_infor = '0; q_rd_en = 1'b0;
    tick(); tick();
    chk("reset_valid", 128'(q_rd_valid), 128'd0);
    chk("reset_count", 128'(q_count), 128'd0);
    chk("reset_drop", 128'(q_drop_cnt), 128'd0);
    chk("reset_flags", 128'({sfd_err, ts_stale}), 128'd0);
    chk("reset_data", 128'(q_rd_data), 128'd0);
    rst_n = 1'b1; tick();
    pop1();

    send_frame(7, 8'hD5, 48'd5, 32'd100, 0, 0);
    tick(); tick();
    verdict(1, 32'h1234ABCD, 0);
    chk("t1_count", 128'(q_count), 128'd1);
    chk("t1_data", 128'(q_rd_data), {16'd0, 48'd5, 32'd100, 32'h1234ABCD});
    pop1();

    gmii_ctrl = 1'b1;
    gmii_data = 8'h55; tick();
    gmii_data = 8'h55; tick();
    gmii_data = 8'hAA; tick();
    chk("t2_sfd_err", 128'(sfd_err), 128'd1);
    gmii_data = 8'h12; tick();
    chk("t2_sfd_err_end", 128'(sfd_err), 128'd0);
    gmii_ctrl = 1'b0; tick();
    verdict(1, 32'h22, 0);
    chk("t2_count", 128'(q_count), 128'd0);

    send_frame(3, 8'hD5, 48'd6, 32'd60, 0, 0);
    verdict(0, 32'h33, 0);
    verdict(1, 32'h34, 0);
    chk("notfound_count", 128'(q_count), 128'd0);

    s0 = stale_seen;
    send_frame(7, 8'hD5, 48'd7, 32'd200, 0, 0);
    send_frame(2, 8'hD5, 48'd8, 32'd300, 0, 0);
    verdict(1, 32'hBEEF, 0);
    chk("t3_stale", 128'(stale_seen - s0), 128'd1);
    chk("t3_data", 128'(q_rd_data), {16'd0, 48'd8, 32'd300, 32'hBEEF});
    pop1();

    s0 = stale_seen;
    send_frame(7, 8'hD5, 48'd20, 32'd20, 0, 0);
    send_frame(7, 8'hD5, 48'd21, 32'd21, 1, 32'hAA);
    chk("same_cycle_count", 128'(q_count), 128'd1);
    chk("same_cycle_data", 128'(q_rd_data), {16'd0, 48'd20, 32'd20, 32'hAA});
    verdict(1, 32'hBB, 0);
    chk("same_cycle_stale", 128'(stale_seen - s0), 128'd0);
    pop1();
    chk("same_cycle_second", 128'(q_rd_data), {16'd0, 48'd21, 32'd21, 32'hBB});
    pop1();

    for (int i = 0; i < DEPTH + 3; i++) begin
      send_frame(7, 8'hD5, 48'(100 + i), 32'(1000 * i), 0, 0);
      verdict(1, 32'(i), 0);
    end
    chk("t4_count", 128'(q_count), 128'd16);
    chk("t4_drop", 128'(q_drop_cnt), 128'd3);
    chk("t4_head", 128'(q_rd_data), {16'd0, 48'd100, 32'd0, 32'd0});

    send_frame(7, 8'hD5, 48'd200, 32'd0, 0, 0);
    verdict(1, 32'h100, 1);
    chk("t5_count", 128'(q_count), 128'd16);
    chk("t5_drop", 128'(q_drop_cnt), 128'd3);
    for (int i = 1; i < DEPTH; i++) begin
      chk("t4_order", 128'(q_rd_data[31:0]), 128'(i));
      pop1();
    end
    chk("t5_tail", 128'(q_rd_data), {16'd0, 48'd200, 32'd0, 32'h100});
    pop1();
    chk("drained", 128'(q_count), 128'd0);

`ifdef TS_CORR_EN
    ts_corr_ns = 16'd20;
    send_frame(7, 8'hD5, 48'd9, 32'd999_999_990, 0, 0);
    verdict(1, 32'd6, 0);
    chk("t6_carry", 128'(q_rd_data), {16'd0, 48'd10, 32'd10, 32'd6});
    pop1();
    ts_corr_ns = 16'hFFF6;
    send_frame(7, 8'hD5, 48'd9, 32'd5, 0, 0);
    verdict(1, 32'd7, 0);
    chk("t6_borrow", 128'(q_rd_data), {16'd0, 48'd8, 32'd999_999_995, 32'd7});
    pop1();
    ts_corr_ns = 16'd0;
`endif

    send_frame(7, 8'hD5, 48'd30, 32'd30, 0, 0);
    gmii_ctrl = 1'b1;
    gmii_data = 8'h55; tick();
    gmii_data = 8'h55; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    gmii_data = 8'h55; tick();
    gmii_data = 8'hD5; tick();
    gmii_data = 8'h10; tick();
    gmii_ctrl = 1'b0; tick();
    tick();
    verdict(1, 32'h44, 0);
    chk("midreset_count", 128'(q_count), 128'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
